// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the M-extension divide path.
//   F3_*        : funct3 values of the RV32M divide/remainder group.
//   div_op_e    : 2-bit opcode understood by the combinational divider
//                 (equal to funct3[1:0]).
//   div_state_e : issue-controller states.
package mdu_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // The divider opcode is simply the low two funct3 bits.
  function automatic div_op_e f3_to_div_op(input logic [2:0] f3);
    return div_op_e'(f3[1:0]);
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// div_result_cache: one-entry memo of the last divider computation.
//   clk, rst_n     : clock, asynchronous active-low reset (clears the entry)
//   i_wr_en        : store {op1, op2, opcode, result} into the entry
//   i_wr_*         : values to store
//   i_lk_*         : lookup key (incoming op)
//   o_hit          : entry valid and op1/op2/opcode all equal the key
//   o_result       : stored result
module div_result_cache
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_op1,
  input  logic [XLEN-1:0] i_wr_op2,
  input  logic [1:0]      i_wr_opcode,
  input  logic [XLEN-1:0] i_wr_result,
  input  logic [XLEN-1:0] i_lk_op1,
  input  logic [XLEN-1:0] i_lk_op2,
  input  logic [1:0]      i_lk_opcode,
  output logic            o_hit,
  output logic [XLEN-1:0] o_result
);

  logic            r_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  div_op_e         r_opcode;
  logic [XLEN-1:0] r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_opcode <= DIV_OP_DIV;
      r_result <= '0;
    end else if (i_wr_en) begin
      r_valid  <= 1'b1;
      r_op1    <= i_wr_op1;
      r_op2    <= i_wr_op2;
      r_opcode <= div_op_e'(i_wr_opcode);
      r_result <= i_wr_result;
    end
  end

  // Value-agnostic match: divide-by-zero and overflow results are cached
  // exactly like any other result.
  always_comb begin
    o_hit    = r_valid && (r_op1 == i_lk_op1) && (r_op2 == i_lk_op2) &&
               (r_opcode == div_op_e'(i_lk_opcode));
    o_result = r_result;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/retire controller in front of the combinational
// 32-bit divider in EX. Operands are registered so the divider is a
// DIV_LAT-cycle multicycle path; the result is handed to EX/MEM with a
// valid/ready handshake. A one-entry cache retires a repeated op at once.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : kill in-flight op, back to IDLE
//   in_valid/in_ready     : op handshake from ID/EX
//   in_funct3/op1/op2/rd  : op fields
//   div_opcode/op1/op2    : registered divider inputs
//   div_result            : divider output (combinational)
//   out_valid/out_ready   : result handshake to EX/MEM
//   out_result/out_rd     : registered result and destination
//   busy                  : WAIT or DONE
module div_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DIV_LAT = 4,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [4:0]      in_rd,
  output logic [1:0]      div_opcode,
  output logic [XLEN-1:0] div_op1,
  output logic [XLEN-1:0] div_op2,
  input  logic [XLEN-1:0] div_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam logic [3:0] LP_LAT = 4'(DIV_LAT);

  div_state_e      r_state;
  div_state_e      w_next_state;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_div_op1;
  logic [XLEN-1:0] r_div_op2;
  div_op_e         r_div_opcode;
  logic [XLEN-1:0] r_out_result;
  logic [4:0]      r_out_rd;

  logic            w_accept;
  logic            w_hit;
  logic            w_wait_last;
  logic            w_cache_wr;
  logic [XLEN-1:0] w_cache_result;

  // funct3[2] is always set for this group; requiring it keeps any stray
  // non-divide encoding from ever reaching the divider.
  assign w_accept    = in_valid && (r_state == IDLE) && in_funct3[2] && !flush;
  assign w_wait_last = (r_state == WAIT) && (r_cnt == 4'd1);
  // A flushed computation is never memoised.
  assign w_cache_wr  = w_wait_last && !flush;

  div_result_cache #(
    .XLEN(XLEN)
  ) u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_cache_wr),
    .i_wr_op1   (r_div_op1),
    .i_wr_op2   (r_div_op2),
    .i_wr_opcode(r_div_opcode),
    .i_wr_result(div_result),
    .i_lk_op1   (in_op1),
    .i_lk_op2   (in_op2),
    .i_lk_opcode(in_funct3[1:0]),
    .o_hit      (w_hit),
    .o_result   (w_cache_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next_state = w_hit ? DONE : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (w_wait_last) w_next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_div_op1    <= '0;
      r_div_op2    <= '0;
      r_div_opcode <= DIV_OP_DIV;
      r_out_result <= '0;
      r_out_rd     <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_div_op1    <= in_op1;
      r_div_op2    <= in_op2;
      r_div_opcode <= f3_to_div_op(in_funct3);
      r_out_rd     <= in_rd;
      if (w_hit) r_out_result <= w_cache_result;
      else       r_cnt        <= LP_LAT;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
      if (w_wait_last) r_out_result <= div_result;
    end
  end

  always_comb begin
    div_opcode = r_div_opcode;
    div_op1    = r_div_op1;
    div_op2    = r_div_op2;
    out_result = r_out_result;
    out_rd     = r_out_rd;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [4:0]  in_rd;
  logic [1:0]  div_opcode;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [31:0] div_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference cache: the last op that completed without a flush.
  bit          m_cv = 1'b0;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [1:0]  m_op;

  always #5 clk = ~clk;

  div_issue_ctrl #(
    .DIV_LAT(LAT),
    .XLEN   (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct3 (in_funct3),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_rd     (in_rd),
    .div_opcode(div_opcode),
    .div_op1   (div_op1),
    .div_op2   (div_op2),
    .div_result(div_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_rd    (out_rd),
    .busy      (busy)
  );

  // RISC-V M-extension division semantics.
  function automatic logic [31:0] ref_div(input logic [1:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (opc)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Behavioural divider fed by the controller's registered operands.
  always_comb div_result = ref_div(div_opcode, div_op1, div_op2);

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    return (m_cv && m_a == a && m_b == b && m_op == f3[1:0]) ? 0 : int'(LAT);
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    m_cv = 1'b1;
    m_a  = a;
    m_b  = b;
    m_op = f3[1:0];
  endtask

  // Issue one op from IDLE, report edges from accept to out_valid, the
  // retired result/rd, then complete the handshake after `hold` stalls.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold, output int lat,
                       output logic [31:0] res, output logic [4:0] rdo, output bit to);
    int w;
    to  = 1'b0;
    lat = 0;
    res = '0;
    rdo = '0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_op1    = a;
    in_op2    = b;
    in_rd     = rd;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      to       = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      to = 1'b1;
      return;
    end
    res = out_result;
    rdo = out_rd;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_funct3 = 3'b100;
    in_op1    = '0;
    in_op2    = '0;
    in_rd     = '0;
    out_ready = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_ctrl: got %b expected 100", {in_ready, out_valid, busy});
    else n_pass++;
    n_checks++;
    if ({out_result, out_rd, div_op1, div_op2, div_opcode} !== '0)
      $display("FAIL reset_data: got res=%h rd=%0d op1=%h op2=%h opc=%0d expected all zero",
               out_result, out_rd, div_op1, div_op2, div_opcode);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m_cv  = 1'b0;
  endtask

  task automatic test_basic();
    int          w;
    logic [31:0] ea;
    ea = 32'd100;
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = 3'b100;
    in_op1    = ea;
    in_op2    = 32'd7;
    in_rd     = 5'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < int'(LAT); k++) begin
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b001)
        $display("FAIL basic_wait%0d: got rdy/val/busy=%b expected 001", k, {in_ready, out_valid, busy});
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd14 || out_rd !== 5'd5)
      $display("FAIL basic_result: got valid=%b res=%0d rd=%0d expected 1 14 5", out_valid, out_result, out_rd);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL basic_retire: got rdy/val/busy=%b expected 100", {in_ready, out_valid, busy});
    else n_pass++;
    model_store(3'b100, ea, 32'd7);
    w = 0;
  endtask

  task automatic test_cache_hit();
    logic [2:0]  f3s  [2] = '{3'b100, 3'b110};
    logic [31:0] exps [2] = '{32'd14, 32'd2};
    int          lats [2] = '{0, int'(LAT)};
    int          lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    bit          to;
    for (int i = 0; i < 2; i++) begin
      do_op(f3s[i], 32'd100, 32'd7, 5'(i + 10), 0, lat, res, rdo, to);
      n_checks++;
      if (to || lat != lats[i] || res !== exps[i] || rdo !== 5'(i + 10))
        $display("FAIL cache_op%0d: got to=%0d lat=%0d res=%0d rd=%0d expected lat=%0d res=%0d rd=%0d",
                 i, to, lat, res, rdo, lats[i], exps[i], i + 10);
      else n_pass++;
      model_store(f3s[i], 32'd100, 32'd7);
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s  [2] = '{3'b101, 3'b110};
    logic [31:0] as   [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs   [2] = '{32'd0, 32'hFFFF_FFFF};
    logic [31:0] exps [2] = '{32'hFFFF_FFFF, 32'd0};
    int          lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    bit          to;
    for (int i = 0; i < 2; i++) begin
      do_op(f3s[i], as[i], bs[i], 5'd31, 1, lat, res, rdo, to);
      n_checks++;
      if (to || lat != int'(LAT) || res !== exps[i] || rdo !== 5'd31)
        $display("FAIL special%0d: got to=%0d lat=%0d res=%h rd=%0d expected lat=%0d res=%h rd=31",
                 i, to, lat, res, rdo, LAT, exps[i]);
      else n_pass++;
      model_store(f3s[i], as[i], bs[i]);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int el;
    el = exp_lat(3'b101, 32'd1000, 32'd33);
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = 3'b101;
    in_op1    = 32'd1000;
    in_op2    = 32'd33;
    in_rd     = 5'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != el) $display("FAIL bp_latency: got %0d expected %0d", lat, el);
    else n_pass++;
    // A new op waits while the old result is stalled.
    in_valid  = 1'b1;
    in_funct3 = 3'b111;
    in_rd     = 5'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd7 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b res=%0d rd=%0d rdy=%b expected 1 30 7 0",
                 k, out_valid, out_result, out_rd, in_ready);
      else n_pass++;
    end
    model_store(3'b101, 32'd1000, 32'd33);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rd !== 5'd7)
      $display("FAIL bp_handshake: got rdy=%b valid=%b rd=%0d expected 1 0 7", in_ready, out_valid, out_rd);
    else n_pass++;
    el = exp_lat(3'b111, 32'd1000, 32'd33);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != el || out_result !== 32'd10 || out_rd !== 5'd9)
      $display("FAIL bp_second: got lat=%0d res=%0d rd=%0d expected %0d 10 9", lat, out_result, out_rd, el);
    else n_pass++;
    model_store(3'b111, 32'd1000, 32'd33);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int          lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    bit          to;
    bit          seen;
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = 3'b100;
    in_op1    = 32'd9;
    in_op2    = 32'd3;
    in_rd     = 5'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL flush_wait: got rdy/val/busy=%b expected 100", {in_ready, out_valid, busy});
    else n_pass++;
    // Accept in the flush cycle is dropped.
    flush    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL flush_quiet: got activity after flush expected none");
    else n_pass++;
    do_op(3'b100, 32'd9, 32'd3, 5'd3, 0, lat, res, rdo, to);
    n_checks++;
    if (to || lat != int'(LAT) || res !== 32'd3 || rdo !== 5'd3)
      $display("FAIL flush_reissue: got to=%0d lat=%0d res=%0d rd=%0d expected lat=%0d res=3 rd=3",
               to, lat, res, rdo, LAT);
    else n_pass++;
    model_store(3'b100, 32'd9, 32'd3);
  endtask

  task automatic test_async_reset();
    int          lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    bit          to;
    int          el;
    el = exp_lat(3'b100, 32'd55, 32'd5);
    do_op(3'b100, 32'd55, 32'd5, 5'd12, 0, lat, res, rdo, to);
    n_checks++;
    if (to || lat != el || res !== 32'd11)
      $display("FAIL ar_first: got to=%0d lat=%0d res=%0d expected lat=%0d res=11", to, lat, res, el);
    else n_pass++;
    model_store(3'b100, 32'd55, 32'd5);
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = 3'b101;
    in_op1    = 32'd8;
    in_op2    = 32'd2;
    in_rd     = 5'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || {out_result, out_rd, div_op1, div_op2, div_opcode} !== '0)
      $display("FAIL ar_mid_wait: got rdy/val/busy=%b res=%h rd=%0d op1=%h expected 100 and zeros",
               {in_ready, out_valid, busy}, out_result, out_rd, div_op1);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m_cv  = 1'b0;
    do_op(3'b100, 32'd55, 32'd5, 5'd12, 0, lat, res, rdo, to);
    n_checks++;
    if (to || lat != int'(LAT) || res !== 32'd11 || rdo !== 5'd12)
      $display("FAIL ar_cache_cleared: got to=%0d lat=%0d res=%0d rd=%0d expected lat=%0d res=11 rd=12",
               to, lat, res, rdo, LAT);
    else n_pass++;
    model_store(3'b100, 32'd55, 32'd5);
  endtask

  task automatic test_random();
    logic [31:0] pool [6] = '{32'd0, 32'd1, 32'd7, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          el;
    int          lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    bit          to;
    f3 = 3'b100;
    a  = 32'd1;
    b  = 32'd1;
    for (int i = 0; i < 30; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        f3 = 3'b100 | 3'($urandom_range(0, 3));
        a  = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
        b  = pool[$urandom_range(0, 5)];
      end
      rd = 5'($urandom);
      el = exp_lat(f3, a, b);
      do_op(f3, a, b, rd, $urandom_range(0, 2), lat, res, rdo, to);
      n_checks++;
      if (to || lat != el || res !== ref_div(f3[1:0], a, b) || rdo !== rd)
        $display("FAIL rand%0d: f3=%b a=%h b=%h got to=%0d lat=%0d res=%h rd=%0d expected lat=%0d res=%h rd=%0d",
                 i, f3, a, b, to, lat, res, rdo, el, ref_div(f3[1:0], a, b), rd);
      else n_pass++;
      model_store(f3, a, b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_cache_hit();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
